// File: rtl/shift_restorer.sv
// Receive-side inverse of the 4-in/7-out left shifter: restores the data word and flags lost set bits.
// Optional macro SHIFT_RESTORER_FAST_EN replaces the one-bit-per-cycle shift with a single-cycle barrel shift.
module shift_restorer #(
    parameter  int unsigned DW = 4,
    parameter  int unsigned SW = 2,
    localparam int unsigned OW = DW + (1 << SW) - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [OW-1:0] I,
    input  logic [SW-1:0] S,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] Out,
    output logic          err
);

    localparam int unsigned CW = SW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [DW-1:0] out_q, out_d;
    logic          err_q, err_d;

`ifdef SHIFT_RESTORER_FAST_EN
    logic [OW-1:0] fast_shifted;
    logic [OW-1:0] fast_lost_mask;
`else
    logic [OW-1:0] word_q, word_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_q, acc_d;
    logic [OW-1:0] step_word;
    logic          step_acc;
`endif

    // Next-state, datapath and result-load logic
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        err_d   = err_q;
`ifdef SHIFT_RESTORER_FAST_EN
        fast_shifted   = I >> S;
        fast_lost_mask = ~({OW{1'b1}} << S);
`else
        word_d    = word_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        step_word = word_q >> 1;
        step_acc  = acc_q | word_q[0];
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef SHIFT_RESTORER_FAST_EN
                    out_d   = fast_shifted[DW-1:0];
                    err_d   = (|(I & fast_lost_mask)) | (|fast_shifted[OW-1:DW]);
                    state_d = DONE;
`else
                    word_d = I;
                    cnt_d  = CW'(S);
                    acc_d  = 1'b0;
                    if (S == '0) begin
                        out_d   = I[DW-1:0];
                        err_d   = |I[OW-1:DW];
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
`endif
                end
            end
`ifndef SHIFT_RESTORER_FAST_EN
            SHIFT: begin
                word_d = step_word;
                acc_d  = step_acc;
                cnt_d  = cnt_q - CW'(1);
                // Last shift: result is loaded on the same edge the state enters DONE
                if (cnt_q == CW'(1)) begin
                    out_d   = step_word[DW-1:0];
                    err_d   = step_acc | (|step_word[OW-1:DW]);
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            err_q       <= 1'b0;
`ifndef SHIFT_RESTORER_FAST_EN
            word_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            out_q       <= out_d;
            err_q       <= err_d;
`ifndef SHIFT_RESTORER_FAST_EN
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Out       = out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_shift_restorer.sv
// Scoreboard bench for shift_restorer: driver pushes hand-computed results, a negedge monitor checks them.
module tb_shift_restorer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] I;
    logic [1:0] S;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Out;
    logic       err;

    typedef struct {
        logic [3:0] out;
        logic       err;
        int         acc_cyc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic prev_valid = 1'b0;

    shift_restorer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .I         (I),
        .S         (S),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every cycle the DUT presents a result; pop on handshake
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("Out", int'(Out), int'(sb[0].out));
                chk("err", int'(err), int'(sb[0].err));
                if (!prev_valid) chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
                if (out_ready) void'(sb.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] iv, input logic [1:0] sv,
                        input logic [3:0] eo, input logic ee);
        exp_t e;
        in_valid = 1'b1;
        I        = iv;
        S        = sv;
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        chk("accept_ready", int'(in_ready), 1);
        e.out     = eo;
        e.err     = ee;
        e.acc_cyc = cyc;
`ifdef SHIFT_RESTORER_FAST_EN
        e.lat     = 1;
`else
        e.lat     = 1 + int'(sv);
`endif
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
        I        = 7'h55;
        S        = 2'd3;
    endtask

    // With out_ready high: in_ready stays low until the cycle after the handshake
    task automatic wait_done();
        int seen = 0;
        for (int i = 0; i < 20; i++) begin
            chk("busy_in_ready", int'(in_ready), 0);
            if (out_valid) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk("done_seen", seen, 1);
        tick();
        chk("post_hs_out_valid", int'(out_valid), 0);
        chk("post_hs_in_ready", int'(in_ready), 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_Out"}, int'(Out), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        I         = '0;
        S         = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        chk_reset_state("reset");

        send(7'b0101000, 2'd3, 4'b0101, 1'b0);
        wait_done();
        send(7'b0001011, 2'd0, 4'b1011, 1'b0);
        wait_done();
        send(7'b1111000, 2'd3, 4'b1111, 1'b0);
        wait_done();

        send(7'b0000011, 2'd2, 4'b0000, 1'b1);
        wait_done();
        send(7'b1000000, 2'd1, 4'b0000, 1'b1);
        wait_done();
        send(7'b0011100, 2'd2, 4'b0111, 1'b0);
        wait_done();

        // Backpressure: result held 6 cycles while a stray request is ignored
        out_ready = 1'b0;
        send(7'b0010100, 2'd2, 4'b0101, 1'b0);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        chk("bp_valid_seen", int'(out_valid), 1);
        in_valid = 1'b1;
        I        = 7'b1111111;
        S        = 2'd0;
        for (int i = 0; i < 6; i++) begin
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", int'(out_valid), 0);
        chk("bp_release_in_ready", int'(in_ready), 1);

        // Reset one cycle after accept discards the transaction
        out_ready = 1'b0;
        send(7'b1010000, 2'd3, 4'b1010, 1'b0);
        rst_n = 1'b0;
        tick();
        sb.delete();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk_reset_state("midop_reset");
        send(7'b0000110, 2'd1, 4'b0011, 1'b0);
        wait_done();

        tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
